// File: rtl/shape_reader.sv
// Debounces the exported shape word, commits it at frame boundaries and answers per-cell queries.
// Queries: 2-cycle fixed latency, one per cycle, no backpressure.
module shape_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int GRID_COLS     = 10,
    parameter int GRID_ROWS     = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] shape_in,
    input  logic        frame_start,
    input  logic        query_valid,
    input  logic [3:0]  query_col,
    input  logic [4:0]  query_row,
    output logic        pix_valid,
    output logic        pix_hit,
    output logic [2:0]  pix_color,
    output logic        shape_changed,
    output logic [7:0]  update_count
);

    localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [4:0] COL_LIM  = 5'(GRID_COLS);
    localparam logic [5:0] ROW_LIM  = 6'(GRID_ROWS);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t      state;
    logic [31:0] sample_r;
    logic [31:0] candidate;
    logic [31:0] pending;
    logic [31:0] active;
    logic [3:0]  cnt;

    logic        s1_valid;
    logic        s1_in_grid;
    logic        s1_shape_vld;
    logic [5:0]  s1_dx;
    logic [5:0]  s1_dy;
    logic [15:0] s1_mask;
    logic [2:0]  s1_color;

    logic        in_box;
    logic        hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_r <= '0;
        end else begin
            sample_r <= shape_in;
        end
    end

    // A sample equal to pending while settling is still a candidate; it completes without effect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            candidate <= '0;
            pending   <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_r != pending) begin
                        candidate <= sample_r;
                        cnt       <= 4'd1;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (sample_r != candidate) begin
                        candidate <= sample_r;
                        cnt       <= 4'd1;
                    end else if (cnt == CNT_LAST) begin
                        pending <= candidate;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    // Commit takes pending as it stood before this edge, so a same-edge completion waits a frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active        <= '0;
            shape_changed <= 1'b0;
            update_count  <= '0;
        end else begin
            shape_changed <= 1'b0;
            if (frame_start) begin
                active <= pending;
                if (pending != active) begin
                    shape_changed <= 1'b1;
                    update_count  <= update_count + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_in_grid   <= 1'b0;
            s1_shape_vld <= 1'b0;
            s1_dx        <= '0;
            s1_dy        <= '0;
            s1_mask      <= '0;
            s1_color     <= '0;
        end else begin
            s1_valid     <= query_valid;
            s1_in_grid   <= ({1'b0, query_col} < COL_LIM) && ({1'b0, query_row} < ROW_LIM);
            s1_dx        <= {2'b00, query_col} - {2'b00, active[19:16]};
            s1_dy        <= {1'b0, query_row} - {1'b0, active[24:20]};
            s1_shape_vld <= active[31];
            s1_mask      <= active[15:0];
            s1_color     <= active[27:25];
        end
    end

    // Offsets outside 0..3 (including negative ones) fail the upper-bits-zero test.
    always_comb begin
        in_box = (s1_dx[5:2] == 4'd0) && (s1_dy[5:2] == 4'd0);
        hit    = s1_valid && s1_shape_vld && s1_in_grid && in_box
                 && s1_mask[{s1_dy[1:0], s1_dx[1:0]}];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix_hit   <= 1'b0;
            pix_color <= '0;
        end else begin
            pix_valid <= s1_valid;
            pix_hit   <= hit;
            pix_color <= hit ? s1_color : 3'd0;
        end
    end

endmodule

// File: tb/tb_shape_reader.sv
// Bench for shape_reader: query tables, directed multi-cycle sequences and a random run against a model.
module tb_shape_reader;

    localparam int S = 4;
    localparam logic [31:0] W1 = 32'h8220_00F0; // X=0 Y=2 colour 1, mask row 1
    localparam logic [31:0] WC = 32'h8658_FFFF; // X=8 Y=5 colour 3, full mask
    localparam logic [31:0] W3 = 32'h8473_000F; // X=3 Y=7 colour 2, row 0 all
    localparam logic [31:0] W4 = 32'h8A73_0009; // X=3 Y=7 colour 5, row 0 cols 0,3

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] shape_in;
    logic        frame_start;
    logic        query_valid;
    logic [3:0]  query_col;
    logic [4:0]  query_row;
    logic        pix_valid;
    logic        pix_hit;
    logic [2:0]  pix_color;
    logic        shape_changed;
    logic [7:0]  update_count;

    shape_reader #(.STABLE_CYCLES(S), .GRID_COLS(10), .GRID_ROWS(20)) dut (
        .clock(clock), .reset(reset), .shape_in(shape_in), .frame_start(frame_start),
        .query_valid(query_valid), .query_col(query_col), .query_row(query_row),
        .pix_valid(pix_valid), .pix_hit(pix_hit), .pix_color(pix_color),
        .shape_changed(shape_changed), .update_count(update_count)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        int col;
        int row;
        int hit;
        int color;
    } qvec_t;

    qvec_t tab1[7];
    qvec_t tabc[9];

    // Reference model state
    logic [31:0] m_sample, m_pending, m_active;
    logic [31:0] hist[$];
    logic [7:0]  m_count;
    int          m_changed;
    int          s1_v, s1_h, s1_c, o_v, o_h, o_c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_out(input string name, input int v, input int h, input int c);
        chk({name, ".valid"}, 32'(pix_valid), v);
        chk({name, ".hit"},   32'(pix_hit),   h);
        chk({name, ".color"}, 32'(pix_color), c);
    endtask

    task automatic chk_commit(input string name, input int ch, input int cnt);
        chk({name, ".changed"}, 32'(shape_changed), ch);
        chk({name, ".count"},   32'(update_count),  cnt);
    endtask

    // Cell coverage straight from the word layout: clipped by the grid, no wrap, negatives miss.
    function automatic int model_hit(input logic [31:0] w, input int col, input int row);
        int c, r;
        if (!w[31] || col >= 10 || row >= 20) return 0;
        c = col - int'(w[19:16]);
        r = row - int'(w[24:20]);
        if (c < 0 || c > 3 || r < 0 || r > 3) return 0;
        return int'(w[4*r + c]);
    endfunction

    task automatic model_reset();
        m_sample = '0; m_pending = '0; m_active = '0; m_count = '0; m_changed = 0;
        hist.delete();
        s1_v = 0; s1_h = 0; s1_c = 0; o_v = 0; o_h = 0; o_c = 0;
    endtask

    // Pending becomes V once the last S registered samples are all V.
    task automatic model_step();
        bit same;
        o_v = s1_v; o_h = s1_h; o_c = s1_c;
        s1_v = int'(query_valid);
        s1_h = query_valid ? model_hit(m_active, int'(query_col), int'(query_row)) : 0;
        s1_c = s1_h ? int'(m_active[27:25]) : 0;
        m_changed = 0;
        if (frame_start) begin
            if (m_pending != m_active) begin
                m_changed = 1;
                m_count++;
            end
            m_active = m_pending;
        end
        hist.push_back(m_sample);
        if (hist.size() > S) void'(hist.pop_front());
        if (hist.size() == S) begin
            same = 1'b1;
            foreach (hist[k]) if (hist[k] != hist[0]) same = 1'b0;
            if (same) m_pending = hist[0];
        end
        m_sample = shape_in;
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) model_reset();
        else model_step();
        @(negedge clock);
    endtask

    task automatic query(input string name, input int col, input int row, input int h, input int c);
        query_valid = 1'b1;
        query_col   = 4'(col);
        query_row   = 5'(row);
        step();
        query_valid = 1'b0;
        step();
        chk_out(name, 1, h, c);
    endtask

    task automatic commit();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        logic [31:0] pool[6];
        logic [31:0] w;
        int exp_h[20], exp_c[20];

        tab1[0] = '{2, 3, 1, 1}; tab1[1] = '{2, 2, 0, 0}; tab1[2] = '{0, 3, 1, 1};
        tab1[3] = '{3, 3, 1, 1}; tab1[4] = '{4, 3, 0, 0}; tab1[5] = '{0, 4, 0, 0};
        tab1[6] = '{0, 1, 0, 0};
        tabc[0] = '{9, 5, 1, 3};  tabc[1] = '{8, 5, 1, 3};  tabc[2] = '{10, 5, 0, 0};
        tabc[3] = '{0, 6, 0, 0};  tabc[4] = '{12, 5, 0, 0}; tabc[5] = '{9, 8, 1, 3};
        tabc[6] = '{9, 9, 0, 0};  tabc[7] = '{8, 4, 0, 0};  tabc[8] = '{7, 5, 0, 0};

        model_reset();
        reset = 1'b1; shape_in = '0; frame_start = 1'b1;
        query_valid = 1'b1; query_col = 4'd2; query_row = 5'd3;
        #12;
        chk_out("in_reset", 0, 0, 0);
        chk_commit("in_reset", 0, 0);
        @(negedge clock);
        reset = 1'b0;
        step();
        chk_out("first_edge", 0, 0, 0);
        chk_commit("first_edge", 0, 0);
        frame_start = 1'b0; query_valid = 1'b0;
        step();
        chk_out("first_query", 1, 0, 0);

        // Basic commit and query table
        shape_in = W1;
        repeat (5) step();
        commit();
        chk_commit("commit1", 1, 1);
        step();
        chk_commit("commit1_after", 0, 1);
        foreach (tab1[i]) query($sformatf("t1_%0d", i), tab1[i].col, tab1[i].row, tab1[i].hit, tab1[i].color);

        // Three-cycle glitch is rejected
        shape_in = WC;
        repeat (3) step();
        shape_in = W1;
        repeat (6) step();
        commit();
        chk_commit("glitch", 0, 1);
        query("glitch_q", 2, 3, 1, 1);

        // Four-cycle hold is accepted
        shape_in = WC;
        repeat (4) step();
        shape_in = W1;
        step();
        commit();
        chk_commit("hold4", 1, 2);
        foreach (tabc[i]) query($sformatf("clip_%0d", i), tabc[i].col, tabc[i].row, tabc[i].hit, tabc[i].color);

        // Same-edge race: completion on the frame_start edge is deferred
        commit();
        chk_commit("recommit", 1, 3);
        shape_in = W3;
        repeat (4) step();
        commit();
        chk_commit("race_hold", 0, 3);
        query("race_q", 2, 3, 1, 1);
        commit();
        chk_commit("race_next", 1, 4);
        step();
        chk_commit("race_once", 0, 4);

        // Back-to-back queries with a commit on query 10's sampling edge
        shape_in = W4;
        repeat (5) step();
        for (int j = 0; j < 20; j++) begin
            w = (j <= 10) ? W3 : W4;
            exp_h[j] = model_hit(w, (j + 10) % 16, 7);
            exp_c[j] = exp_h[j] ? int'(w[27:25]) : 0;
        end
        for (int i = 0; i < 22; i++) begin
            query_valid = (i < 20);
            query_col   = 4'((i + 10) % 16);
            query_row   = 5'd7;
            frame_start = (i == 10);
            step();
            if (i == 10) chk_commit("tp_commit", 1, 5);
            if (i >= 1 && i <= 20) chk_out($sformatf("tp%0d", i - 1), 1, exp_h[i-1], exp_c[i-1]);
            if (i == 21) chk("tp_end.valid", 32'(pix_valid), 0);
        end
        frame_start = 1'b0; query_valid = 1'b0;

        // Async reset while settling with queries in flight
        shape_in = W1; query_valid = 1'b1; query_col = 4'd3; query_row = 5'd7;
        repeat (2) step();
        chk_out("pre_reset", 1, 1, 5);
        #2 reset = 1'b1;
        #1;
        chk_out("async_reset", 0, 0, 0);
        chk_commit("async_reset", 0, 0);
        step();
        reset = 1'b0;
        query_col = 4'd2; query_row = 5'd3;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("post_reset%0d.hit", k), 32'(pix_hit), 0);
        end
        query_valid = 1'b0;
        commit();
        chk_commit("fresh", 1, 1);
        query("fresh_q", 2, 3, 1, 1);

        // Random run against the model
        for (int p = 0; p < 6; p++)
            pool[p] = {1'($urandom_range(0, 4) != 0), 3'($urandom), 3'($urandom),
                       5'($urandom_range(0, 19)), 4'($urandom_range(0, 9)), 16'($urandom)};
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 5) == 0) shape_in = pool[$urandom_range(0, 5)];
            frame_start = ($urandom_range(0, 7) == 0);
            query_valid = ($urandom_range(0, 3) != 0);
            query_col   = 4'($urandom_range(0, 11));
            query_row   = 5'($urandom_range(0, 21));
            step();
            chk($sformatf("rnd%0d.valid", n),   32'(pix_valid),     o_v);
            chk($sformatf("rnd%0d.hit", n),     32'(pix_hit),       o_h);
            chk($sformatf("rnd%0d.color", n),   32'(pix_color),     o_c);
            chk($sformatf("rnd%0d.changed", n), 32'(shape_changed), m_changed);
            chk($sformatf("rnd%0d.count", n),   32'(update_count),  32'(m_count));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
